spmv_row_accum: RTL and testbench
=================================

Name: spmv_row_accum

Overview:
- Downstream stage of the SpMV 32x32 signed multiplier. Consumes its registered product stream, one product per nonzero in CSR order.
- Sums the products of each matrix row into y[row]. Emits one result per row over a valid/ready handshake to the y-vector writer.
- Tracks the row index and signals completion after the last row's result is accepted.

Parameters:
- DATA_WIDTH, 32, width of products, accumulator and results (matches multiplier dout).
- ROW_WIDTH, 16, width of row count and row index.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse; begins a matrix pass when IDLE.
- num_rows  in  ROW_WIDTH  rows in pass, sampled on accepted start.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse at pass completion.
- in_valid  in  1  product beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  signed product.
- in_last  in  1  beat is final beat of its row.
- in_empty  in  1  beat carries no product (in_data ignored, contributes 0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WIDTH  y[row], signed sum modulo 2^DATA_WIDTH.
- out_row  out  ROW_WIDTH  row index of out_data.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; acc, row_cnt, rows_q, out_data, out_row = 0.
  - out_valid, done, busy = 0.
  - Deassertion is synchronised by the user; no partial results survive a mid-pass reset.
- States:
  - IDLE:
    - start with num_rows!=0 -> RUN. Latch rows_q, row_cnt=0, acc=0.
    - start with num_rows==0 -> done=1 next cycle, remain IDLE.
  - RUN:
    - in_ready = (!out_valid || out_ready). Must not depend on in_valid, in_last or in_empty.
    - Accepted beat, in_last=0: acc <= acc + (in_empty ? 0 : in_data).
    - Accepted beat, in_last=1:
      - out_data <= acc + (in_empty ? 0 : in_data); out_row <= row_cnt; out_valid <= 1.
      - acc <= 0; row_cnt <= row_cnt+1.
      - If row_cnt == rows_q-1 -> FLUSH.
  - FLUSH: in_ready=0. When out_valid && out_ready: out_valid<=0, done=1 next cycle, -> IDLE.
  - IDLE: in_ready=0. Beats offered in IDLE are not consumed.
- Output register:
  - Single entry. out_valid clears on out_ready unless a new result loads the same cycle.
  - Simultaneous drain and load in RUN: new result replaces old; out_valid stays 1.
  - out_data and out_row hold stable while out_valid && !out_ready.
- Empty rows: upstream sends one beat with in_empty=1, in_last=1. It yields out_data=0 for that row.
- Arithmetic: two's-complement add, wrap modulo 2^DATA_WIDTH, no saturation or overflow flag.
- Latency: result visible one cycle after its last beat is accepted. Throughput one beat per cycle while out_ready=1.
- start while busy is ignored. row_cnt never exceeds rows_q-1.
- done is high exactly one cycle per pass. busy=0 in the done cycle.

Test Plan:
- Basic row: start, num_rows=1; beats 3, -5, 10 (last on 10), out_ready=1 -> out_data=8, out_row=0 one cycle after the last beat; done pulse after accept; busy=0.
- Multi-row with empty row: num_rows=3; row0 {7 last}, row1 {empty,last}, row2 {2, 4 last} -> outputs (0,7), (1,0), (2,6) in order; single done.
- Backpressure: out_ready=0 while row0 result pending -> in_ready=0, out_data/out_row held for 5 cycles. Raising out_ready -> accepted once, stream resumes, no beat lost or duplicated.
- Wrap: beats 0x7FFFFFFF, 1 (last) -> out_data=0x80000000. Beats 0xFFFFFFFF, 1 (last) -> 0.
- Zero rows and ignored start: start with num_rows=0 -> done next cycle, busy never 1. start pulsed mid-RUN -> no effect on row_cnt or acc.
- Reset mid-pass: reset low after 2 of 4 beats of row1 -> out_valid=0, busy=0 immediately. New start with num_rows=1, beat 9 last -> out_data=9, out_row=0 (no stale acc).

Source files
------------

// File: rtl/spmv_row_accum_if.sv
// Product-stream / result-stream bundle for the SpMV row accumulator.
//   in_valid/in_ready/in_data/in_last/in_empty : product beats from the multiplier
//   out_valid/out_ready/out_data/out_row       : per-row results to the y-vector writer
// slave  : accumulator view (consumes beats, produces results)
// master : environment view (produces beats, consumes results)
interface spmv_row_accum_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_empty;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ROW_WIDTH-1:0]  out_row;

  modport slave (
    input  in_valid, in_data, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_data, out_row
  );

  modport master (
    output in_valid, in_data, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_data, out_row
  );
endinterface

// File: rtl/spmv_row_accum.sv
// Sums the signed product stream of each CSR matrix row into y[row] and
// hands one result per row to the y-vector writer.
//   clk      : clock, all state on rising edge
//   reset    : asynchronous active-low reset
//   start    : one-cycle pulse, begins a pass when idle
//   num_rows : rows in the pass, sampled with an accepted start
//   busy     : pass in progress
//   done     : one-cycle pulse when the last row's result has been taken
//   strm     : product beats in, row results out (spmv_row_accum_if.slave)
//
// state | meaning
// IDLE  | waiting for start; beats are not consumed
// RUN   | accumulating beats, emitting one result per in_last beat
// FLUSH | last row emitted, waiting for downstream to take it
module spmv_row_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROW_WIDTH-1:0] num_rows,
  output logic                 busy,
  output logic                 done,
  spmv_row_accum_if.slave      strm
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] beat_val;
  logic [DATA_WIDTH-1:0] row_sum;
  logic [ROW_WIDTH-1:0]  row_cnt;
  logic [ROW_WIDTH-1:0]  rows_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ROW_WIDTH-1:0]  out_row_q;
  logic                  beat_fire;
  logic                  out_fire;
  logic                  last_row;

  always_comb begin
    beat_val = strm.in_empty ? '0 : strm.in_data;
    row_sum  = acc + beat_val;
  end

  // Ready only looks at the output register, so a result waiting on
  // downstream stalls the stream, while a draining result lets a beat through.
  assign strm.in_ready  = (state == RUN) && (!out_valid_q || strm.out_ready);
  assign beat_fire      = strm.in_valid && strm.in_ready;
  assign out_fire       = out_valid_q && strm.out_ready;
  assign last_row       = (row_cnt == rows_q - ROW_WIDTH'(1));

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_row   = out_row_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      row_cnt     <= '0;
      rows_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              state   <= RUN;
              rows_q  <= num_rows;
              row_cnt <= '0;
              acc     <= '0;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (beat_fire && strm.in_last) begin
            // A new result overwrites a draining one; out_valid stays high.
            out_data_q  <= row_sum;
            out_row_q   <= row_cnt;
            out_valid_q <= 1'b1;
            acc         <= '0;
            if (last_row) begin
              state <= FLUSH;
            end else begin
              row_cnt <= row_cnt + ROW_WIDTH'(1);
            end
          end else begin
            if (beat_fire) begin
              acc <= row_sum;
            end
            if (out_fire) begin
              out_valid_q <= 1'b0;
            end
          end
        end

        FLUSH: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_accum.sv
module tb_spmv_row_accum;
  localparam int DW = 32;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [RW-1:0] num_rows;
  logic          busy;
  logic          done;

  spmv_row_accum_if #(.DATA_WIDTH(DW), .ROW_WIDTH(RW)) bus ();

  spmv_row_accum #(.DATA_WIDTH(DW), .ROW_WIDTH(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_rows (num_rows),
    .busy     (busy),
    .done     (done),
    .strm     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] row;
    logic [DW-1:0] data;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   d0;

  // Reference model: running row sum and row index of the pass in flight.
  logic [RW-1:0] m_row;
  logic [DW-1:0] m_sum;

  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic [RW-1:0] hold_row;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every accepted result against the model queue, plus
  // stability of a stalled result and busy low during done.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("busy_in_done_cycle", 32'(busy), 32'd0);
    end
    if (!reset) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        chk("stall_data_held", bus.out_data, hold_data);
        chk("stall_row_held", 32'(bus.out_row), 32'(hold_row));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got row %0d data 0x%0h, expected no result", bus.out_row, bus.out_data);
        end else begin
          chk("result_row", 32'(bus.out_row), 32'(exp_q[0].row));
          chk("result_data", bus.out_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        got_q.push_back('{row: bus.out_row, data: bus.out_data});
      end
      hold_prev <= bus.out_valid && !bus.out_ready;
      hold_data <= bus.out_data;
      hold_row  <= bus.out_row;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic empty);
    logic taken = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      taken = bus.in_ready;
      step();
      if (taken) break;
    end
    bus.in_valid = 1'b0;
    if (!taken) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept_timeout: got no in_ready, expected acceptance of 0x%0h", d);
    end else begin
      if (!empty) m_sum = m_sum + d;
      if (last) begin
        exp_q.push_back('{row: m_row, data: m_sum});
        m_row = m_row + 16'd1;
        m_sum = '0;
      end
    end
  endtask

  task automatic start_pass(input logic [RW-1:0] n);
    start    = 1'b1;
    num_rows = n;
    step();
    start = 1'b0;
    m_row = '0;
    m_sum = '0;
    got_q.delete();
  endtask

  task automatic wait_done(input int n_results);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done pulse, expected one");
    end
    step();
    step();
    step();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("results_outstanding", 32'(exp_q.size()), 32'd0);
    chk("result_count", 32'(got_q.size()), 32'(n_results));
  endtask

  task automatic check_got(input int idx, input logic [RW-1:0] row, input logic [DW-1:0] data);
    if (idx < got_q.size()) begin
      chk("literal_row", 32'(got_q[idx].row), 32'(row));
      chk("literal_data", got_q[idx].data, data);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL literal_missing: got %0d results, expected entry %0d", got_q.size(), idx);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    num_rows      = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_empty  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_row", 32'(bus.out_row), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Beat offered while idle must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd99;
    bus.in_last  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Basic row: 3 - 5 + 10 = 8.
    d0 = done_cnt;
    start_pass(16'd1);
    send_beat(32'd3, 1'b0, 1'b0);
    send_beat(32'hFFFF_FFFB, 1'b0, 1'b0);
    send_beat(32'd10, 1'b1, 1'b0);
    @(negedge clk);
    chk("basic_valid_latency", 32'(bus.out_valid), 32'd1);
    chk("basic_data_latency", bus.out_data, 32'd8);
    chk("basic_row_latency", 32'(bus.out_row), 32'd0);
    step();
    wait_done(1);
    check_got(0, 16'd0, 32'd8);
    chk("basic_busy_after", 32'(busy), 32'd0);

    // Three rows, middle one empty.
    d0 = done_cnt;
    start_pass(16'd3);
    chk("multi_busy", 32'(busy), 32'd1);
    send_beat(32'd7, 1'b1, 1'b0);
    send_beat(32'hDEAD_BEEF, 1'b1, 1'b1);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd4, 1'b1, 1'b0);
    wait_done(3);
    check_got(0, 16'd0, 32'd7);
    check_got(1, 16'd1, 32'd0);
    check_got(2, 16'd2, 32'd6);

    // Backpressure on row0 result while row1 beat waits.
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    start_pass(16'd2);
    send_beat(32'd5, 1'b0, 1'b0);
    send_beat(32'd6, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd100;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_data", bus.out_data, 32'd11);
      chk("bp_out_row", 32'(bus.out_row), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    send_beat(32'd100, 1'b0, 1'b0);
    send_beat(32'd1, 1'b1, 1'b0);
    wait_done(2);
    check_got(0, 16'd0, 32'd11);
    check_got(1, 16'd1, 32'd101);

    // Wrap-around arithmetic.
    d0 = done_cnt;
    start_pass(16'd2);
    send_beat(32'h7FFF_FFFF, 1'b0, 1'b0);
    send_beat(32'd1, 1'b1, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_beat(32'd1, 1'b1, 1'b0);
    wait_done(2);
    check_got(0, 16'd0, 32'h8000_0000);
    check_got(1, 16'd1, 32'd0);

    // Zero-row pass: done next cycle, never busy.
    d0 = done_cnt;
    start    = 1'b1;
    num_rows = 16'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    chk("zero_done_clear", 32'(done), 32'd0);
    chk("zero_busy_after", 32'(busy), 32'd0);
    step();
    chk("zero_done_pulses", 32'(done_cnt - d0), 32'd1);

    // start mid-RUN is ignored.
    d0 = done_cnt;
    start_pass(16'd1);
    send_beat(32'd4, 1'b0, 1'b0);
    start    = 1'b1;
    num_rows = 16'd5;
    step();
    start = 1'b0;
    send_beat(32'd6, 1'b1, 1'b0);
    wait_done(1);
    check_got(0, 16'd0, 32'd10);

    // Reset in the middle of row1.
    start_pass(16'd2);
    send_beat(32'd1, 1'b1, 1'b0);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
    step();
    d0 = done_cnt;
    start_pass(16'd1);
    send_beat(32'd9, 1'b1, 1'b0);
    wait_done(1);
    check_got(0, 16'd0, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
